// File: rtl/sensor_conditioner_pkg.sv
// Shared types and constants for the four-channel sensor conditioner.
package sensor_conditioner_pkg;

    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        LO_CNT    = 2'd1,
        HI_STABLE = 2'd2,
        HI_CNT    = 2'd3
    } ch_state_t;

    localparam int CH_G  = 3;
    localparam int CH_T  = 2;
    localparam int CH_CC = 1;
    localparam int CH_B  = 0;

    localparam int NUM_CH        = 4;
    localparam int DEF_DB_CYCLES = 20;
    localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/sensor_conditioner_channel.sv
// One debounce channel: 2-flop synchronizer, candidate-level FSM with
// stability counter, and a registered rising-edge pulse.
//
// state     | meaning
// ----------+----------------------------------------------
// LO_STABLE | accepted level 0, input agrees
// LO_CNT    | accepted level 0, counting a candidate high
// HI_STABLE | accepted level 1, input agrees
// HI_CNT    | accepted level 1, counting a candidate low
module debounce_channel
    import sensor_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       r_sync;
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             w_sync;

    assign w_sync = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b00;
            r_state <= LO_STABLE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

    // Entering a CNT state loads 1 because that cycle already counts as stable.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        case (r_state)
            LO_STABLE: begin
                if (w_sync) begin
                    w_state_nxt = LO_CNT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            LO_CNT: begin
                if (!w_sync) begin
                    w_state_nxt = LO_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = HI_STABLE;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HI_STABLE: begin
                if (!w_sync) begin
                    w_state_nxt = HI_CNT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            HI_CNT: begin
                if (w_sync) begin
                    w_state_nxt = HI_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = LO_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = LO_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_clean = (r_state == HI_STABLE) || (r_state == HI_CNT);
    assign o_rise  = r_rise;

endmodule

// File: rtl/sensor_conditioner.sv
// Four independent debounced sensor channels with sticky, acknowledgeable
// rising-edge event flags and a registered any-event summary.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] clean,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] evt,
    input  logic [NUM_CH-1:0] evt_ack,
    output logic              any_evt
);

    logic [NUM_CH-1:0] w_clean;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] r_evt;
    logic              r_any_evt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst_n (rst),
            .i_raw   (raw_in[gi]),
            .o_clean (w_clean[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    // A rise in the same cycle as an ack keeps the flag set.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_evt     <= '0;
            r_any_evt <= 1'b0;
        end else begin
            r_evt     <= w_rise | (r_evt & ~evt_ack);
            r_any_evt <= |r_evt;
        end
    end

    assign clean   = w_clean;
    assign rise    = w_rise;
    assign evt     = r_evt;
    assign any_evt = r_any_evt;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: cycle model feeding a scoreboard queue plus
// directed latency checks at DB_CYCLES = 4.
module tb_sensor_conditioner;

    localparam int DB = 4;

    typedef struct packed {
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] evt;
        logic       any;
    } exp_t;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] raw_in = 4'b0000;
    logic [3:0] evt_ack = 4'b0000;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] evt;
    logic       any_evt;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [3:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_evt = '0;
    logic       m_any = 1'b0;
    logic [3:0] m_rise_n, m_evt_n;
    logic       m_any_n;
    int         m_run [4] = '{default: 0};
    logic [3:0] prev_rise = '0;

    always #5 CLK = ~CLK;

    sensor_conditioner #(.DB_CYCLES(DB), .CNT_W(5)) dut (
        .CLK     (CLK),
        .rst     (rst),
        .raw_in  (raw_in),
        .clean   (clean),
        .rise    (rise),
        .evt     (evt),
        .evt_ack (evt_ack),
        .any_evt (any_evt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: a level is accepted once the synchronized input has
    // disagreed with it for DB consecutive cycles.
    always @(posedge CLK) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_evt = '0; m_any = 1'b0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            m_any_n  = |m_evt;
            m_evt_n  = m_rise | (m_evt & ~evt_ack);
            m_rise_n = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_clean[i]  = ~m_clean[i];
                        m_rise_n[i] = m_clean[i];
                        m_run[i]    = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1; m_s1 = raw_in;
            m_rise = m_rise_n; m_evt = m_evt_n; m_any = m_any_n;
        end
        sb_q.push_back('{m_clean, m_rise, m_evt, m_any});
    end

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_clean", clean, mon_e.clean);
            check("sb_rise", rise, mon_e.rise);
            check("sb_evt", evt, mon_e.evt);
            check("sb_any_evt", any_evt, mon_e.any);
            check("rise_consec", rise & prev_rise, 4'b0000);
            prev_rise = rise;
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        rst = 1'b1;

        // Quiet inputs after reset.
        for (int k = 1; k <= 20; k++) begin
            step();
            check("idle_clean", clean, 4'b0000);
            check("idle_rise", rise, 4'b0000);
            check("idle_evt", evt, 4'b0000);
        end

        // Channel G accepted high: exact latency of clean/rise/evt/any_evt.
        @(negedge CLK) raw_in[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("g_rise", rise[3], k == 6);
            check("g_clean", clean[3], k >= 6);
            check("g_evt", evt[3], k >= 7);
            check("g_any", any_evt, k >= 8);
        end
        @(negedge CLK) evt_ack = 4'b1000;
        step();
        check("g_ack", evt[3], 1'b0);
        @(negedge CLK) evt_ack = 4'b0000;

        // Short pulse on CC rejected.
        @(negedge CLK) raw_in[1] = 1'b1;
        repeat (3) @(negedge CLK);
        raw_in[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("cc_glitch", {clean[1], rise[1], evt[1]}, 3'b000);
        end

        // Channel B: set evt, drop, then re-rise with a coincident ack.
        @(negedge CLK) raw_in[0] = 1'b1;
        repeat (6) step();
        check("b_rise1", rise[0], 1'b1);
        repeat (3) step();
        @(negedge CLK) raw_in[0] = 1'b0;
        repeat (8) step();
        check("b_low", clean[0], 1'b0);
        check("b_evt_held", evt[0], 1'b1);
        @(negedge CLK) raw_in[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("b_rise2", rise[0], k == 6);
        end
        @(negedge CLK) evt_ack[0] = 1'b1;
        step();
        check("b_set_wins", evt[0], 1'b1);
        step();
        check("b_ack_clear", evt[0], 1'b0);
        @(negedge CLK) evt_ack[0] = 1'b0;
        step();
        check("b_any_clear", any_evt, 1'b0);

        // All four channels together.
        @(negedge CLK) raw_in = 4'b0000;
        repeat (8) step();
        check("all_lo", clean, 4'b0000);
        @(negedge CLK) raw_in = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("all_rise", rise, (k == 6) ? 4'b1111 : 4'b0000);
            if (k == 7) check("all_evt", evt, 4'b1111);
        end
        repeat (3) step();
        @(negedge CLK) raw_in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("all_fall_clean", clean, (k >= 6) ? 4'b0000 : 4'b1111);
            check("all_fall_rise", rise, 4'b0000);
        end
        @(negedge CLK) evt_ack = 4'b1111;
        @(negedge CLK) evt_ack = 4'b0000;

        // Reset in the middle of a T count, raw still high on release.
        @(negedge CLK) raw_in[2] = 1'b1;
        repeat (4) step();
        @(negedge CLK) rst = 1'b0;
        @(negedge CLK);
        @(negedge CLK) rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("t_rst_rise", rise[2], k == 6);
            check("t_rst_clean", clean[2], k >= 6);
        end

        // Random stretch: slow toggles, random acks, occasional reset.
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) raw_in[i] = ~raw_in[i];
            evt_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rst = ($urandom_range(0, 99) != 0);
        end
        @(negedge CLK);
        rst = 1'b1;
        evt_ack = 4'b0000;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter: DB_CYCLES, default 20, consecutive stable cycles required to accept a new level (legal range 2..2^CNT_W-1).
REQ-002 Parameter: CNT_W, default 5, debounce counter width.
REQ-003 Port: CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset.
REQ-005 Port: raw_in  input  4  asynchronous sensor lines: bit3 G, bit2 T, bit1 CC, bit0 B.
REQ-006 Port: clean  output  4  debounced level per channel, same bit order; feeds the sequencer condition mux.
REQ-007 Port: rise  output  4  one-cycle pulse per channel on accepted 0->1 transition.
REQ-008 Port: evt  output  4  sticky per-channel event flag, set by rise, cleared by evt_ack.
REQ-009 Port: evt_ack  input  4  per-channel clear request for evt, sampled every cycle.
REQ-010 Port: any_evt  output  1  registered OR of evt.

Function
REQ-011 Each raw_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL run an independent 4-state FSM: LO_STABLE, LO_CNT (candidate high), HI_STABLE, HI_CNT (candidate low).
REQ-013 LO_STABLE -> LO_CNT when synchronized bit = 1; counter loads 1.
REQ-014 LO_CNT: sync = 1 -> counter increments; sync = 0 -> back to LO_STABLE, counter cleared (glitch rejected, no output change).
REQ-015 LO_CNT with counter = DB_CYCLES-1 and sync = 1 -> HI_STABLE at next edge; clean goes 1 and rise pulses 1 in the same cycle.
REQ-016 HI_STABLE/HI_CNT SHALL mirror REQ-013..015 for the 1->0 direction; clean goes 0, rise not asserted.
REQ-017 Latency: raw edge held stable -> clean change after exactly 2 + DB_CYCLES CLK edges; pulses shorter than DB_CYCLES synchronized cycles SHALL never change clean.
REQ-018 rise SHALL be high for exactly one cycle per accepted rising transition; never two consecutive cycles.
REQ-019 evt[i] set on rise[i]; cleared on evt_ack[i] when rise[i] = 0; simultaneous rise[i] and evt_ack[i] -> evt[i] stays 1 (set wins).
REQ-020 evt_ack on a channel with evt = 0 SHALL have no effect.
REQ-021 any_evt SHALL equal OR of evt delayed by one cycle.
REQ-022 Counter SHALL saturate-free: never exceeds DB_CYCLES-1; no wrap-around possible.
REQ-023 Channels SHALL not interact; simultaneous transitions on all four channels handled independently in the same cycle.

Reset
REQ-024 While rst = 0 at a CLK edge: synchronizer flops, counters, clean, rise, evt, any_evt = 0; all FSMs LO_STABLE.
REQ-025 Reset asserted mid-count SHALL discard the count; a raw line held high through reset release produces clean = 1 and one rise pulse 2 + DB_CYCLES edges after release.
REQ-026 Reset SHALL dominate evt_ack and raw_in activity.

Structure
REQ-027 Shared package SHALL hold: channel-state encoding, channel index constants (CH_G = 3, CH_T = 2, CH_CC = 1, CH_B = 0), default DB_CYCLES and CNT_W.
REQ-028 One sub-module, debounce_channel (synchronizer, FSM, counter, rise), SHALL be instantiated four times; evt/any_evt logic stays in the top.

Verification (DB_CYCLES = 4)
REQ-029 Reset release, raw_in = 4'b0000 held 20 cycles -> clean = 0, rise = 0, evt = 0 throughout.
REQ-030 raw_in[3] 0->1 held -> clean[3] = 1 and rise[3] single pulse exactly 6 edges after the change; evt[3] = 1 and any_evt = 1 one cycle later.
REQ-031 raw_in[1] high for 3 cycles then low -> clean[1], rise[1], evt[1] remain 0.
REQ-032 evt[0] = 1, evt_ack[0] pulsed coincident with a new rise[0] -> evt[0] stays 1; ack one cycle later alone -> evt[0] = 0, any_evt = 0 next cycle.
REQ-033 raw_in = 4'b1111 simultaneously -> rise = 4'b1111 in one cycle, evt = 4'b1111; then 1->0 on all -> clean = 0 after 6 edges, no rise.
REQ-034 rst asserted 2 cycles into a LO_CNT on raw_in[2], released with raw_in[2] still high -> rise[2] exactly 6 edges after release, only once.
